// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the main-memory port arbiter.
//   arb_state_t         - arbiter FSM states (IDLE, BUSY, RESP)
//   owner_t             - which requester owns the current transaction
//   ARB_TIMEOUT_DEFAULT - default ack wait limit, used only when the design
//                         is built with ARB_TIMEOUT_EN defined
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_DATA  = 1'b0,
    OWN_INSTR = 1'b1
  } owner_t;

  localparam int ARB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin chooser.
//   d_req      in  data side is requesting
//   i_req      in  fetch side is requesting
//   last_grant in  side that won the previous grant
//   winner     out side to grant; only meaningful while d_req or i_req is high
// On a tie the side that did not win last time is picked, so neither side
// can starve the other.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic   d_req,
  input  logic   i_req,
  input  owner_t last_grant,
  output owner_t winner
);

  // Pick a winner: lone requester wins, ties go to the side not granted last.
  always_comb begin
    winner = OWN_DATA;
    if (d_req && i_req) begin
      if (last_grant == OWN_DATA) begin
        winner = OWN_INSTR;
      end else begin
        winner = OWN_DATA;
      end
    end else if (i_req) begin
      winner = OWN_INSTR;
    end else begin
      winner = OWN_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single main-memory port between the data
// cacheline (loads/stores, byte ops) and the instruction-fetch path (word
// reads). A granted request is held on the mem_* bus until mem_ack_i, the
// read data is registered, and the owner gets a one-cycle done pulse.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   d_req_i .. d_write_data_i    data side request, held until d_done_o
//   d_read_data_o, d_done_o      data side result / completion pulse
//   i_req_i, i_address_i         fetch request, held until i_done_o
//   i_read_data_o, i_done_o      fetch result / completion pulse
//   mem_req_o .. mem_byte_op_o   memory request bus, non-zero only in BUSY
//   mem_ack_i, mem_read_data_i   memory completion and read data
//   err_o                        timeout flag, pulses together with done
//
// Build option: define ARB_TIMEOUT_EN to abort a transaction after TIMEOUT
// BUSY cycles without ack (done with zero data and err_o). Without it, BUSY
// waits indefinitely and err_o is tied low.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             d_req_i,
  input  logic             d_write_enable_i,
  input  logic             d_byte_op_i,
  input  logic [WIDTH-1:0] d_address_i,
  input  logic [WIDTH-1:0] d_write_data_i,
  output logic [WIDTH-1:0] d_read_data_o,
  output logic             d_done_o,
  input  logic             i_req_i,
  input  logic [WIDTH-1:0] i_address_i,
  output logic [WIDTH-1:0] i_read_data_o,
  output logic             i_done_o,
  output logic             mem_req_o,
  output logic [WIDTH-1:0] mem_address_o,
  output logic [WIDTH-1:0] mem_write_data_o,
  output logic             mem_write_enable_o,
  output logic             mem_byte_op_o,
  input  logic             mem_ack_i,
  input  logic [WIDTH-1:0] mem_read_data_i,
  output logic             err_o
);

  arb_state_t       state_r, state_s;
  owner_t           owner_r, owner_s;
  owner_t           last_grant_r, last_grant_s;
  owner_t           winner_s;
  logic [WIDTH-1:0] addr_r, addr_s;
  logic [WIDTH-1:0] wdata_r, wdata_s;
  logic             we_r, we_s;
  logic             byte_op_r, byte_op_s;
  logic [WIDTH-1:0] rdata_r, rdata_s;
  logic             err_r, err_s;
  logic             busy_s;
  logic             resp_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_r, cnt_s;
`else
  // TIMEOUT only sizes the wait counter, which this build does not have.
  logic timeout_unused_s;
  assign timeout_unused_s = (TIMEOUT > 0);
`endif

  rr_pick2 u_pick (
    .d_req      (d_req_i),
    .i_req      (i_req_i),
    .last_grant (last_grant_r),
    .winner     (winner_s)
  );

  // State and transaction latches; reset wins over any pending ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      owner_r      <= OWN_DATA;
      last_grant_r <= OWN_INSTR;
      addr_r       <= '0;
      wdata_r      <= '0;
      we_r         <= 1'b0;
      byte_op_r    <= 1'b0;
      rdata_r      <= '0;
      err_r        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_r        <= '0;
`endif
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      last_grant_r <= last_grant_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      we_r         <= we_s;
      byte_op_r    <= byte_op_s;
      rdata_r      <= rdata_s;
      err_r        <= err_s;
`ifdef ARB_TIMEOUT_EN
      cnt_r        <= cnt_s;
`endif
    end
  end

  // Next-state logic: grant in IDLE, wait for ack in BUSY, one RESP cycle.
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    last_grant_s = last_grant_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    we_s         = we_r;
    byte_op_s    = byte_op_r;
    rdata_s      = rdata_r;
    err_s        = err_r;
`ifdef ARB_TIMEOUT_EN
    cnt_s        = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (d_req_i || i_req_i) begin
          state_s      = BUSY;
          owner_s      = winner_s;
          last_grant_s = winner_s;
          rdata_s      = '0;
          err_s        = 1'b0;
`ifdef ARB_TIMEOUT_EN
          cnt_s        = '0;
`endif
          if (winner_s == OWN_DATA) begin
            addr_s    = d_address_i;
            wdata_s   = d_write_data_i;
            we_s      = d_write_enable_i;
            byte_op_s = d_byte_op_i;
          end else begin
            // Fetches are plain word reads.
            addr_s    = i_address_i;
            wdata_s   = '0;
            we_s      = 1'b0;
            byte_op_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          // Stores return zero rather than whatever the bus carries.
          rdata_s = we_r ? '0 : mem_read_data_i;
          state_s = RESP;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_r == CNT_LAST) begin
          // An ack in this same cycle is taken by the branch above instead.
          rdata_s = '0;
          err_s   = 1'b1;
          state_s = RESP;
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
          state_s = BUSY;
`else
        end else begin
          state_s = BUSY;
`endif
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign busy_s = (state_r == BUSY);
  assign resp_s = (state_r == RESP);

  assign mem_req_o          = busy_s;
  assign mem_address_o      = busy_s ? addr_r  : '0;
  assign mem_write_data_o   = busy_s ? wdata_r : '0;
  assign mem_write_enable_o = busy_s & we_r;
  assign mem_byte_op_o      = busy_s & byte_op_r;

  assign d_done_o      = resp_s & (owner_r == OWN_DATA);
  assign i_done_o      = resp_s & (owner_r == OWN_INSTR);
  assign d_read_data_o = d_done_o ? rdata_r : '0;
  assign i_read_data_o = i_done_o ? rdata_r : '0;

`ifdef ARB_TIMEOUT_EN
  assign err_o = resp_s & err_r;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter. Expected
// transactions are queued when requests are driven; a memory model answers
// the mem_* bus and a monitor checks the bus against the queue head and pops
// it on each done pulse.
module tb_mem_port_arbiter;

  localparam int W  = 32;
  localparam int TO = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         d_req_i, d_write_enable_i, d_byte_op_i;
  logic [W-1:0] d_address_i, d_write_data_i, d_read_data_o;
  logic         d_done_o;
  logic         i_req_i;
  logic [W-1:0] i_address_i, i_read_data_o;
  logic         i_done_o;
  logic         mem_req_o, mem_write_enable_o, mem_byte_op_o;
  logic [W-1:0] mem_address_o, mem_write_data_o;
  logic         mem_ack_i;
  logic [W-1:0] mem_read_data_i;
  logic         err_o;

  mem_port_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .d_req_i            (d_req_i),
    .d_write_enable_i   (d_write_enable_i),
    .d_byte_op_i        (d_byte_op_i),
    .d_address_i        (d_address_i),
    .d_write_data_i     (d_write_data_i),
    .d_read_data_o      (d_read_data_o),
    .d_done_o           (d_done_o),
    .i_req_i            (i_req_i),
    .i_address_i        (i_address_i),
    .i_read_data_o      (i_read_data_o),
    .i_done_o           (i_done_o),
    .mem_req_o          (mem_req_o),
    .mem_address_o      (mem_address_o),
    .mem_write_data_o   (mem_write_data_o),
    .mem_write_enable_o (mem_write_enable_o),
    .mem_byte_op_o      (mem_byte_op_o),
    .mem_ack_i          (mem_ack_i),
    .mem_read_data_i    (mem_read_data_i),
    .err_o              (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          data_side;
    logic [31:0] addr;
    bit          we;
    bit          bop;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } txn_t;

  txn_t exp_q[$];
  txn_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0;
  int txn_cnt = 0, busy_cnt = 0, last_busy_len = 0;
  int d_done_cnt = 0, i_done_cnt = 0;
  int last_d_done_cyc = 0, last_i_done_cyc = 0;
  int ack_delay = 1;
  bit mem_model_en = 1'b1;
  bit i_hold = 1'b0, i_drop_next = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    else return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory model: ack in the ack_delay-th BUSY cycle (0 = never).
  initial begin
    mem_ack_i = 1'b0;
    mem_read_data_i = 32'd0;
    forever begin
      @(negedge clk_i);
      if (mem_model_en) begin
        if (mem_req_o) begin
          busy_cnt++;
          if (busy_cnt == 1) txn_cnt++;
          if (ack_delay != 0 && busy_cnt == ack_delay) begin
            mem_ack_i = 1'b1;
            mem_read_data_i = mem_val(mem_address_o);
          end else begin
            mem_ack_i = 1'b0;
            mem_read_data_i = $urandom;
          end
        end else begin
          if (busy_cnt != 0) last_busy_len = busy_cnt;
          busy_cnt = 0;
          mem_ack_i = 1'b0;
          mem_read_data_i = $urandom;
        end
      end
    end
  end

  // Monitor: bus checks against the queue head, done checks pop it.
  initial begin
    forever begin
      @(negedge clk_i);
      if (i_drop_next) begin
        i_req_i = 1'b0;
        i_drop_next = 1'b0;
      end
      if (mem_req_o) begin
        if (exp_q.size() == 0) check_eq("mem_unexpected", 32'(mem_req_o), 32'd0);
        else begin
          check_eq("mem_addr", mem_address_o, exp_q[0].addr);
          check_eq("mem_ctl", {30'd0, mem_write_enable_o, mem_byte_op_o},
                   {30'd0, exp_q[0].we, exp_q[0].bop});
          if (exp_q[0].data_side) check_eq("mem_wdata", mem_write_data_o, exp_q[0].wdata);
        end
      end else begin
        check_eq("mem_idle", mem_address_o | mem_write_data_o |
                 {30'd0, mem_write_enable_o, mem_byte_op_o}, 32'd0);
      end
      if (d_done_o || i_done_o) begin
        if (exp_q.size() == 0) check_eq("done_unexpected", {30'd0, d_done_o, i_done_o}, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          check_eq("done_side", {30'd0, d_done_o, i_done_o}, mon_e.data_side ? 32'd2 : 32'd1);
          check_eq("done_err", 32'(err_o), 32'(mon_e.err));
          if (mon_e.data_side) begin
            check_eq("d_rdata", d_read_data_o, mon_e.rdata);
            check_eq("i_rdata_other", i_read_data_o, 32'd0);
            d_done_cnt++;
            last_d_done_cyc = cyc;
            d_req_i = 1'b0;
          end else begin
            check_eq("i_rdata", i_read_data_o, mon_e.rdata);
            check_eq("d_rdata_other", d_read_data_o, 32'd0);
            i_done_cnt++;
            last_i_done_cyc = cyc;
            if (i_hold) i_drop_next = 1'b1;
            else i_req_i = 1'b0;
          end
        end
      end else begin
        check_eq("err_idle", 32'(err_o), 32'd0);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check_eq({"drain_", tag}, exp_q.size(), 32'd0);
    step(2);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {26'd0, d_done_o, i_done_o, mem_req_o, mem_write_enable_o,
             mem_byte_op_o, err_o}, 32'd0);
    check_eq({tag, "_bus"}, mem_address_o | mem_write_data_o | d_read_data_o | i_read_data_o, 32'd0);
  endtask

  task automatic push_d(input logic [31:0] a, input bit we, input bit bop,
                        input logic [31:0] wd, input bit err);
    txn_t t;
    t.data_side = 1'b1; t.addr = a; t.we = we; t.bop = bop; t.wdata = wd;
    t.rdata = (we || err) ? 32'd0 : mem_val(a);
    t.err = err;
    exp_q.push_back(t);
  endtask

  task automatic push_i(input logic [31:0] a);
    txn_t t;
    t.data_side = 1'b0; t.addr = a; t.we = 1'b0; t.bop = 1'b0; t.wdata = 32'd0;
    t.rdata = mem_val(a); t.err = 1'b0;
    exp_q.push_back(t);
  endtask

  task automatic drive_d(input logic [31:0] a, input bit we, input bit bop, input logic [31:0] wd);
    d_address_i = a; d_write_enable_i = we; d_byte_op_i = bop; d_write_data_i = wd;
    d_req_i = 1'b1;
  endtask

  task automatic drive_i(input logic [31:0] a);
    i_address_i = a;
    i_req_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int t0, n0, i0;
    rst_i = 1'b1;
    d_req_i = 1'b0; d_write_enable_i = 1'b0; d_byte_op_i = 1'b0;
    d_address_i = 32'd0; d_write_data_i = 32'd0;
    i_req_i = 1'b0; i_address_i = 32'd0;
    step(3);
    check_all_zero("reset");
    rst_i = 1'b0;
    step();

    // Tie right after reset: data first, fetch granted after data RESP.
    ack_delay = 1;
    push_d(32'h0000_0040, 1'b0, 1'b0, 32'h1111_2222, 1'b0);
    push_i(32'h0000_0800);
    drive_d(32'h0000_0040, 1'b0, 1'b0, 32'h1111_2222);
    drive_i(32'h0000_0800);
    t0 = cyc;
    drain("pair1");
    check_eq("pair1_d_lat", last_d_done_cyc - t0, 32'd2);
    check_eq("pair1_i_lat", last_i_done_cyc - t0, 32'd5);

    // Single load, ack in third BUSY cycle.
    ack_delay = 3;
    n0 = txn_cnt; i0 = i_done_cnt;
    push_d(32'h0000_0100, 1'b0, 1'b0, 32'h5555_AAAA, 1'b0);
    drive_d(32'h0000_0100, 1'b0, 1'b0, 32'h5555_AAAA);
    t0 = cyc;
    drain("load");
    check_eq("load_lat", last_d_done_cyc - t0, 32'd4);
    check_eq("load_busy_len", last_busy_len, 32'd3);
    check_eq("load_txns", txn_cnt - n0, 32'd1);
    check_eq("load_no_i_done", i_done_cnt - i0, 32'd0);

    // Last grant was data, so the next tie goes to the fetch side.
    ack_delay = 2;
    push_i(32'h0000_0C04);
    push_d(32'h0000_0208, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);
    drive_d(32'h0000_0208, 1'b0, 1'b0, 32'h0BAD_F00D);
    drive_i(32'h0000_0C04);
    t0 = cyc;
    drain("pair2");
    check_eq("pair2_i_lat", last_i_done_cyc - t0, 32'd3);
    check_eq("pair2_d_lat", last_d_done_cyc - t0, 32'd7);

    // Zero-wait byte store.
    ack_delay = 1;
    push_d(32'h0000_0203, 1'b1, 1'b1, 32'h0000_00AB, 1'b0);
    drive_d(32'h0000_0203, 1'b1, 1'b1, 32'h0000_00AB);
    t0 = cyc;
    drain("bstore");
    check_eq("bstore_lat", last_d_done_cyc - t0, 32'd2);
    check_eq("bstore_busy_len", last_busy_len, 32'd1);

    // Fetch held one cycle past done: still a single transaction.
    i_hold = 1'b1;
    ack_delay = 2;
    n0 = txn_cnt; i0 = i_done_cnt;
    push_i(32'h0000_1000);
    drive_i(32'h0000_1000);
    drain("held");
    step(3);
    check_eq("held_txns", txn_cnt - n0, 32'd1);
    check_eq("held_i_dones", i_done_cnt - i0, 32'd1);
    i_hold = 1'b0;

    // Reset in the second BUSY cycle with an ack pending.
    ack_delay = 0;
    push_d(32'h0000_0300, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    drive_d(32'h0000_0300, 1'b0, 1'b0, 32'h0000_0000);
    step();
    check_eq("rst_busy1", 32'(mem_req_o), 32'd1);
    step();
    rst_i = 1'b1;
    d_req_i = 1'b0;
    mem_model_en = 1'b0;
    mem_ack_i = 1'b1;
    mem_read_data_i = 32'hBAD0_0001;
    step();
    rst_i = 1'b0;
    exp_q.delete();
    check_all_zero("rst_mid");
    for (int k = 0; k < 3; k++) begin
      step();
      check_all_zero("rst_late_ack");
    end
    mem_ack_i = 1'b0;
    mem_model_en = 1'b1;
    step(2);

`ifdef ARB_TIMEOUT_EN
    // No ack: abort after TO BUSY cycles with err and zero data.
    ack_delay = 0;
    push_d(32'h0000_0400, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    drive_d(32'h0000_0400, 1'b0, 1'b0, 32'h0000_0000);
    drain("timeout");
    check_eq("timeout_busy_len", last_busy_len, TO);
`endif

    // Normal load completes afterwards.
    ack_delay = 2;
    push_d(32'h0000_0500, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    drive_d(32'h0000_0500, 1'b0, 1'b0, 32'h0000_0000);
    drain("final");
    check_eq("final_busy_len", last_busy_len, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
